debug_unit: RTL and testbench
=============================

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning); all SHALL be overridable:
- LEN, 32, datapath word width.
- N_REGS, 32, register-file entries dumped.
- N_MEM_WORDS, 16, data-memory words dumped.
- READ_LAT, 1, cycles from debug address change to valid read data.

REQ-002 Ports, one per line (name, direction, width, meaning); the clock is `clk`, the reset is `reset`, and reset SHALL be asynchronous and active-low:
- clk, in, 1, single clock.
- reset, in, 1, async active-low reset.
- rx_data, in, 8, received UART byte.
- rx_done, in, 1, one-cycle strobe: rx_data valid.
- tx_data, out, 8, byte to transmit.
- tx_start, out, 1, one-cycle strobe: begin transmitting tx_data.
- tx_done, in, 1, one-cycle strobe: transmitter idle again.
- debug_flag, out, 1, pipeline in debug access mode.
- in_addr_debug, out, LEN, register index or data address for readback.
- in_addr_mem_inst, out, LEN, instruction-memory write address.
- in_ins_to_mem, out, LEN, instruction word to write.
- wea_ram_inst, out, 1, instruction-memory write enable.
- mips_enable, out, 1, pipeline clock enable.
- out_pc, in, LEN, current PC.
- out_reg1_recolector, in, LEN, register readback.
- out_mem_wire, in, LEN, data-memory readback.
- halt_flag, in, 1, halt reached write-back.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, TX_PC, TX_CYC, TX_REG, TX_MEM.
REQ-004 In IDLE, rx_done with byte 0x4C ('L') SHALL go to LOAD_CNT, 0x43 ('C') to RUN, 0x53 ('S') to STEP; any other byte SHALL be ignored.
REQ-005 LOAD_CNT: the next byte SHALL be the instruction count N; N=0 SHALL return to IDLE with no write.
REQ-006 LOAD_BYTE SHALL assemble 4 bytes MSB first; LOAD_WR SHALL pulse wea_ram_inst for exactly 1 cycle with in_addr_mem_inst = 4*index, then increment index; after N words the FSM SHALL go to IDLE.
REQ-007 RUN SHALL hold mips_enable=1 until halt_flag=1 is sampled; mips_enable SHALL be 0 from the next cycle, then go to TX_PC.
REQ-008 STEP SHALL assert mips_enable for exactly 1 cycle, then go to TX_PC; STEP with halt_flag already 1 SHALL skip the enable pulse.
REQ-009 The cycle counter SHALL be LEN bits, SHALL increment on each mips_enable=1 cycle, SHALL wrap modulo 2^LEN, and SHALL clear only on reset or on 'L'.
REQ-010 Each dumped word SHALL be sent MSB first, one byte per tx_start; the next tx_start SHALL wait for tx_done; tx_start and tx_done in the same cycle SHALL never occur.
REQ-011 Dump order SHALL be PC, cycle count, registers 0..N_REGS-1, then memory words 0..N_MEM_WORDS-1 (addresses 4*i); after the last byte the FSM SHALL return to IDLE.
REQ-012 Before capturing readback, in_addr_debug SHALL be stable for READ_LAT cycles.
REQ-013 debug_flag SHALL be 1 in LOAD_* and TX_* states and 0 elsewhere; mips_enable SHALL be 0 whenever debug_flag=1.
REQ-014 rx_done outside IDLE and LOAD_* SHALL be dropped.

Reset
REQ-015 reset=0 SHALL immediately force IDLE and drive every output, counter and index to 0, including mid-load or mid-dump; a partially assembled word SHALL be discarded.

Configuration
REQ-016 Macro DEBUG_MEM_DUMP_EN:
- Defined: TX_MEM is compiled in and the dump is 8+4*N_REGS+4*N_MEM_WORDS bytes.
- Undefined: TX_MEM is absent, the FSM goes from the last register to IDLE, and the dump is 8+4*N_REGS bytes.

Structure
REQ-017 The shared package SHALL hold the state enumeration, the command byte constants (0x4C, 0x43, 0x53) and the byte-per-word constant (4).
REQ-018 A sub-module `word_serializer` (LEN word to MSB-first bytes, with the tx_start/tx_done handshake) SHALL be instantiated once.

Verification
REQ-019 'L', 0x02, bytes 12 34 56 78 AA BB CC DD -> two wea pulses: addr 0 data 0x12345678, then addr 4 data 0xAABBCCDD; FSM ends in IDLE.
REQ-020 'L', 0x00 -> no wea pulse; IDLE within 1 cycle.
REQ-021 'C' with halt_flag rising after 10 enabled cycles -> cycle count 10, first 8 bytes 00 00 00 PC.. then 00 00 00 0A; total 200 bytes with the macro defined, 136 without.
REQ-022 'S' twice -> exactly one mips_enable cycle each, cycle count 1 then 2.
REQ-023 reset asserted after the 3rd byte of a load word -> all outputs 0 in the same cycle; next 'L', 0x01, 4 bytes writes addr 0.
REQ-024 Byte 0x58 in IDLE -> no state change and no tx_start.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// Shared types and constants for the debug unit: FSM states, UART command bytes, word framing.
// The TX_MEM state exists only when DEBUG_MEM_DUMP_EN is defined.
package debug_unit_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CNT,
        LOAD_BYTE,
        LOAD_WR,
        RUN,
        STEP,
        TX_PC,
        TX_CYC,
        TX_REG
`ifdef DEBUG_MEM_DUMP_EN
        , TX_MEM
`endif
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic is_tx_state(input state_t s);
`ifdef DEBUG_MEM_DUMP_EN
        return s inside {TX_PC, TX_CYC, TX_REG, TX_MEM};
`else
        return s inside {TX_PC, TX_CYC, TX_REG};
`endif
    endfunction

endpackage

// File: rtl/debug_unit_word_serializer.sv
// Splits one datapath word into MSB-first bytes for the UART transmitter,
// issuing one tx_start per byte and waiting for tx_done before the next.
module word_serializer #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic [LEN-1:0] word_i,
    input  logic           tx_done_i,
    output logic [7:0]     tx_data_o,
    output logic           tx_start_o,
    output logic           done_o
);
    import debug_unit_pkg::*;

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    logic [LEN-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             active_q, active_d;
    logic             wait_q, wait_d;

    // A byte is offered for exactly one cycle, then the serializer parks until tx_done.
    always_comb begin
        shift_d  = shift_q;
        rem_d    = rem_q;
        active_d = active_q;
        wait_d   = wait_q;
        done_o   = 1'b0;
        if (!active_q) begin
            if (load_i) begin
                shift_d  = word_i;
                rem_d    = CNT_W'(BYTES_PER_WORD);
                active_d = 1'b1;
                wait_d   = 1'b0;
            end
        end else if (!wait_q) begin
            wait_d = 1'b1;
        end else if (tx_done_i) begin
            wait_d = 1'b0;
            if (rem_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end else begin
                shift_d = shift_q << 8;
                rem_d   = rem_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            active_q <= active_d;
            wait_q   <= wait_d;
        end
    end

    assign tx_start_o = active_q & ~wait_q;
    assign tx_data_o  = shift_q[LEN-1 -: 8];

endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: loads instruction memory, runs or steps the pipeline,
// then dumps PC, cycle count and registers (plus data memory when DEBUG_MEM_DUMP_EN is defined).
module debug_unit #(
    parameter int LEN         = 32,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16,
    parameter int READ_LAT    = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_done,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_done,
    output logic           debug_flag,
    output logic [LEN-1:0] in_addr_debug,
    output logic [LEN-1:0] in_addr_mem_inst,
    output logic [LEN-1:0] in_ins_to_mem,
    output logic           wea_ram_inst,
    output logic           mips_enable,
    input  logic [LEN-1:0] out_pc,
    input  logic [LEN-1:0] out_reg1_recolector,
    input  logic [LEN-1:0] out_mem_wire,
    input  logic           halt_flag
);
    import debug_unit_pkg::*;

    localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [LEN-1:0]   idx_q, idx_d;
    logic [LEN-1:0]   word_q, word_d;
    logic [LEN-1:0]   cycle_q, cycle_d;
    logic [1:0]       byte_q, byte_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             sending_q, sending_d;

    logic             is_tx;
    logic             ser_load;
    logic             ser_done;
    logic             word_done;
    logic [LEN-1:0]   ser_word;

    assign is_tx      = is_tx_state(state_q);
    assign debug_flag = is_tx || (state_q inside {LOAD_CNT, LOAD_BYTE, LOAD_WR});
    assign ser_load   = is_tx && !sending_q && (lat_q == LAT_W'(READ_LAT));
    assign word_done  = is_tx && sending_q && ser_done;

    // Readback address and word source per dump phase.
    always_comb begin
        ser_word      = '0;
        in_addr_debug = '0;
        case (state_q)
            TX_PC:  ser_word = out_pc;
            TX_CYC: ser_word = cycle_q;
            TX_REG: begin
                in_addr_debug = idx_q;
                ser_word      = out_reg1_recolector;
            end
`ifdef DEBUG_MEM_DUMP_EN
            TX_MEM: begin
                in_addr_debug = idx_q << 2;
                ser_word      = out_mem_wire;
            end
`endif
            default: ;
        endcase
    end

`ifndef DEBUG_MEM_DUMP_EN
    logic unused_mem;
    assign unused_mem = ^out_mem_wire ^ (N_MEM_WORDS == 0);
`endif

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        idx_d            = idx_q;
        word_d           = word_q;
        cycle_d          = cycle_q;
        byte_d           = byte_q;
        lat_d            = lat_q;
        sending_d        = sending_q;
        mips_enable      = 1'b0;
        wea_ram_inst     = 1'b0;
        in_addr_mem_inst = '0;
        in_ins_to_mem    = '0;

        // Readback settles for READ_LAT cycles on each new address before the word is captured.
        if (is_tx) begin
            if (!sending_q) begin
                if (ser_load) sending_d = 1'b1;
                else          lat_d     = lat_q + LAT_W'(1);
            end else if (ser_done) begin
                sending_d = 1'b0;
                lat_d     = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_LOAD) begin
                        state_d = LOAD_CNT;
                        cycle_d = '0;
                    end else if (rx_data == CMD_CONT) begin
                        state_d = RUN;
                    end else if (rx_data == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
            end
            LOAD_CNT: begin
                if (rx_done) begin
                    count_d = rx_data;
                    idx_d   = '0;
                    word_d  = '0;
                    byte_d  = '0;
                    state_d = (rx_data == 8'd0) ? IDLE : LOAD_BYTE;
                end
            end
            LOAD_BYTE: begin
                if (rx_done) begin
                    word_d = {word_q[LEN-9:0], rx_data};
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = LOAD_WR;
                end
            end
            LOAD_WR: begin
                wea_ram_inst     = 1'b1;
                in_addr_mem_inst = idx_q << 2;
                in_ins_to_mem    = word_q;
                idx_d            = idx_q + LEN'(1);
                state_d          = (idx_q + LEN'(1) == LEN'(count_q)) ? IDLE : LOAD_BYTE;
            end
            RUN: begin
                mips_enable = 1'b1;
                if (halt_flag) begin
                    state_d   = TX_PC;
                    lat_d     = '0;
                    sending_d = 1'b0;
                end
            end
            STEP: begin
                mips_enable = !halt_flag;
                state_d     = TX_PC;
                lat_d       = '0;
                sending_d   = 1'b0;
            end
            TX_PC: begin
                if (word_done) state_d = TX_CYC;
            end
            TX_CYC: begin
                if (word_done) begin
                    state_d = TX_REG;
                    idx_d   = '0;
                end
            end
            TX_REG: begin
                if (word_done) begin
                    if (idx_q == LEN'(N_REGS - 1)) begin
`ifdef DEBUG_MEM_DUMP_EN
                        state_d = TX_MEM;
                        idx_d   = '0;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + LEN'(1);
                    end
                end
            end
`ifdef DEBUG_MEM_DUMP_EN
            TX_MEM: begin
                if (word_done) begin
                    if (idx_q == LEN'(N_MEM_WORDS - 1)) state_d = IDLE;
                    else                               idx_d   = idx_q + LEN'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (mips_enable) cycle_d = cycle_q + LEN'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            cycle_q   <= '0;
            byte_q    <= '0;
            lat_q     <= '0;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            cycle_q   <= cycle_d;
            byte_q    <= byte_d;
            lat_q     <= lat_d;
            sending_q <= sending_d;
        end
    end

    word_serializer #(.LEN(LEN)) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ser_load),
        .word_i    (ser_word),
        .tx_done_i (tx_done),
        .tx_data_o (tx_data),
        .tx_start_o(tx_start),
        .done_o    (ser_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: table of IDLE command bytes, load sequences,
// run/step dumps against a byte-level reference, and reset in the middle of a load.
`timescale 1ns/1ps
module tb_debug_unit;

    localparam int LEN         = 32;
    localparam int N_REGS      = 32;
    localparam int N_MEM_WORDS = 16;
    localparam int READ_LAT    = 1;
`ifdef DEBUG_MEM_DUMP_EN
    localparam int DUMP_BYTES = 8 + 4 * N_REGS + 4 * N_MEM_WORDS;
`else
    localparam int DUMP_BYTES = 8 + 4 * N_REGS;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_done = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_done = 1'b0;
    logic           debug_flag;
    logic [LEN-1:0] in_addr_debug;
    logic [LEN-1:0] in_addr_mem_inst;
    logic [LEN-1:0] in_ins_to_mem;
    logic           wea_ram_inst;
    logic           mips_enable;
    logic [LEN-1:0] out_pc = '0;
    logic [LEN-1:0] out_reg1_recolector = '0;
    logic [LEN-1:0] out_mem_wire = '0;
    logic           halt_flag = 1'b0;

    logic [31:0] regFile [N_REGS];
    logic [31:0] memArr  [N_MEM_WORDS];

    int compared   = 0;
    int mismatched = 0;
    int enCount    = 0;
    int exclViol   = 0;
    int clashCount = 0;
    bit txPending  = 1'b0;
    int txDelay    = 0;

    logic [7:0]  gotBytes[$];
    logic [7:0]  expBytes[$];
    logic [63:0] writes[$];
    logic [31:0] loadWords[$];
    logic [31:0] modelCycles = '0;

    typedef struct {
        logic [7:0] rxByte;
        logic       expDebug;
    } idleVec_t;

    always #5 clk = ~clk;

    debug_unit #(
        .LEN(LEN), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM_WORDS), .READ_LAT(READ_LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx_data            (rx_data),
        .rx_done            (rx_done),
        .tx_data            (tx_data),
        .tx_start           (tx_start),
        .tx_done            (tx_done),
        .debug_flag         (debug_flag),
        .in_addr_debug      (in_addr_debug),
        .in_addr_mem_inst   (in_addr_mem_inst),
        .in_ins_to_mem      (in_ins_to_mem),
        .wea_ram_inst       (wea_ram_inst),
        .mips_enable        (mips_enable),
        .out_pc             (out_pc),
        .out_reg1_recolector(out_reg1_recolector),
        .out_mem_wire       (out_mem_wire),
        .halt_flag          (halt_flag)
    );

    // Register file and data memory with one cycle of read latency
    always @(posedge clk) begin
        out_reg1_recolector <= regFile[in_addr_debug[4:0]];
        out_mem_wire        <= memArr[in_addr_debug[5:2]];
    end

    // UART transmitter model plus observers for writes and enable cycles
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (txPending) begin
            if (txDelay == 0) begin
                tx_done   = 1'b1;
                txPending = 1'b0;
            end else begin
                txDelay--;
            end
        end
        if (tx_start) begin
            if (tx_done) clashCount++;
            gotBytes.push_back(tx_data);
            txPending = 1'b1;
            txDelay   = $urandom_range(0, 2);
        end
        if (wea_ram_inst) writes.push_back({in_addr_mem_inst, in_ins_to_mem});
        if (mips_enable) enCount++;
        if (debug_flag && mips_enable) exclViol++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic randomizeReadback();
        for (int i = 0; i < N_REGS; i++) regFile[i] = $urandom;
        for (int i = 0; i < N_MEM_WORDS; i++) memArr[i] = $urandom;
        out_pc = $urandom;
    endtask

    task automatic pushWord(input logic [31:0] w);
        expBytes.push_back(w[31:24]);
        expBytes.push_back(w[23:16]);
        expBytes.push_back(w[15:8]);
        expBytes.push_back(w[7:0]);
    endtask

    task automatic waitDump();
        int t;
        t = 0;
        while (!(gotBytes.size() >= DUMP_BYTES && !debug_flag && !txPending) && t < 8000) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic checkDump(input string name);
        expBytes.delete();
        pushWord(out_pc);
        pushWord(modelCycles);
        for (int i = 0; i < N_REGS; i++) pushWord(regFile[i]);
`ifdef DEBUG_MEM_DUMP_EN
        for (int i = 0; i < N_MEM_WORDS; i++) pushWord(memArr[i]);
`endif
        checkOutput({name, "_len"}, 64'(gotBytes.size()), 64'(expBytes.size()));
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++)
            checkOutput($sformatf("%s_byte%0d", name, i), 64'(gotBytes[i]), 64'(expBytes[i]));
        checkOutput({name, "_idle"}, 64'(debug_flag), 64'(0));
    endtask

    task automatic doStep(input string name);
        int base;
        int expEn;
        randomizeReadback();
        gotBytes.delete();
        base  = enCount;
        expEn = halt_flag ? 0 : 1;
        applyStimulus(8'h53);
        waitDump();
        checkOutput({name, "_enables"}, 64'(enCount - base), 64'(expEn));
        modelCycles = modelCycles + 32'(expEn);
        checkDump(name);
    endtask

    task automatic doRun(input string name, input int k);
        int base;
        int t;
        randomizeReadback();
        gotBytes.delete();
        base = enCount;
        halt_flag = 1'b0;
        applyStimulus(8'h43);
        t = 0;
        while (t < 1000) begin
            #1;
            if (enCount - base >= k) begin
                halt_flag = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
        waitDump();
        checkOutput({name, "_enables"}, 64'(enCount - base), 64'(k));
        modelCycles = modelCycles + 32'(k);
        checkDump(name);
        halt_flag = 1'b0;
    endtask

    task automatic doLoad(input string name);
        int n;
        n = loadWords.size();
        writes.delete();
        applyStimulus(8'h4C);
        modelCycles = '0;
        applyStimulus(8'(n));
        foreach (loadWords[i]) begin
            logic [31:0] w;
            w = loadWords[i];
            applyStimulus(w[31:24]);
            applyStimulus(w[23:16]);
            applyStimulus(w[15:8]);
            applyStimulus(w[7:0]);
        end
        repeat (3) @(negedge clk);
        #1;
        checkOutput({name, "_count"}, 64'(writes.size()), 64'(n));
        for (int i = 0; i < n && i < writes.size(); i++)
            checkOutput($sformatf("%s_wr%0d", name, i), writes[i], {32'(4 * i), loadWords[i]});
        checkOutput({name, "_idle"}, 64'(debug_flag), 64'(0));
    endtask

    idleVec_t idleVecs[5];

    initial begin
        logic [63:0] allOut;
        int k;

        idleVecs[0] = '{rxByte: 8'h58, expDebug: 1'b0};
        idleVecs[1] = '{rxByte: 8'h00, expDebug: 1'b0};
        idleVecs[2] = '{rxByte: 8'hFF, expDebug: 1'b0};
        idleVecs[3] = '{rxByte: 8'h6C, expDebug: 1'b0};
        idleVecs[4] = '{rxByte: 8'h4C, expDebug: 1'b1};

        for (int i = 0; i < N_REGS; i++) regFile[i] = '0;
        for (int i = 0; i < N_MEM_WORDS; i++) memArr[i] = '0;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        allOut = {32'(in_addr_debug | in_addr_mem_inst | in_ins_to_mem), 8'(tx_data),
                  20'd0, tx_start, debug_flag, wea_ram_inst, mips_enable};
        checkOutput("reset_outputs", allOut, 64'd0);
        reset = 1'b1;

        $display("[TB] IDLE command table");
        foreach (idleVecs[i]) begin
            gotBytes.delete();
            writes.delete();
            applyStimulus(idleVecs[i].rxByte);
            #1;
            checkOutput($sformatf("idle%0d_debug", i), 64'(debug_flag), 64'(idleVecs[i].expDebug));
            checkOutput($sformatf("idle%0d_enable", i), 64'(mips_enable), 64'(0));
            if (idleVecs[i].expDebug) begin
                applyStimulus(8'h00);
                modelCycles = '0;
                #1;
                checkOutput($sformatf("idle%0d_zero_count_exit", i), 64'(debug_flag), 64'(0));
            end
            repeat (3) @(negedge clk);
            checkOutput($sformatf("idle%0d_no_tx", i), 64'(gotBytes.size()), 64'(0));
            checkOutput($sformatf("idle%0d_no_wr", i), 64'(writes.size()), 64'(0));
        end

        $display("[TB] instruction loads");
        loadWords = '{32'h12345678, 32'hAABBCCDD};
        doLoad("load_fixed");
        for (int r = 0; r < 2; r++) begin
            loadWords.delete();
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) loadWords.push_back($urandom);
            doLoad($sformatf("load_rand%0d", r));
        end

        $display("[TB] single steps");
        doStep("step1");
        doStep("step2");
        checkOutput("step_total_cycles", 64'(modelCycles), 64'd2);

        $display("[TB] run to halt");
        applyStimulus(8'h4C);
        applyStimulus(8'h00);
        modelCycles = '0;
        doRun("run10", 10);
        doRun("run_rand", $urandom_range(1, 30));

        halt_flag = 1'b1;
        doStep("step_halted");
        halt_flag = 1'b0;

        $display("[TB] reset during load");
        writes.delete();
        applyStimulus(8'h4C);
        applyStimulus(8'h01);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        #1;
        checkOutput("midload_debug", 64'(debug_flag), 64'(1));
        reset = 1'b0;
        #1;
        allOut = {32'(in_addr_debug | in_addr_mem_inst | in_ins_to_mem), 8'(tx_data),
                  20'd0, tx_start, debug_flag, wea_ram_inst, mips_enable};
        checkOutput("midload_reset_outputs", allOut, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelCycles = '0;
        doStep("step_after_reset");
        loadWords = '{32'hCAFE0042};
        doLoad("load_after_reset");

        checkOutput("enable_while_debug", 64'(exclViol), 64'(0));
        checkOutput("start_done_overlap", 64'(clashCount), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
